ff574_bank_ctl: RTL and testbench

Sequencer and arbiter that shares a bank of NREG 74x574-style registers between NREQ requesters. It generates one clean rising edge per write on the addressed register's clk input, and a bounded active-low output-enable window per read. Reads are sampled from the shared tri-state q bus. The block sits between microcode or bus-master requesters and the register-file flip-flops.

---
 rtl/ff574_bank_ctl_pkg.sv | 28 ++
 rtl/ff574_bank_ctl_rr_arbiter.sv | 50 +++++
 rtl/ff574_bank_ctl.sv | 172 +++++++++++++++++
 tb/tb_ff574_bank_ctl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff574_bank_ctl_pkg.sv
// Shared definitions for the 74x574 register-bank controller.
// Holds the sequencer state encoding, default bank dimensions and a small
// index-width helper used by the top level and the arbiter.
package ff574_bank_ctl_pkg;

  localparam int unsigned DefNreq = 4;
  localparam int unsigned DefNreg = 8;
  localparam int unsigned DefAw   = 3;
  localparam int unsigned DefDw   = 8;

  // Write: Idle->Setup->Strobe->Hold->Ack; read: Idle->Oe->Sample->Ack;
  // out-of-range address: Idle->Ack.
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StOe,
    StSample,
    StAck
  } state_e;

  // Width of an index into n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ff574_bank_ctl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at or above 'pointer', wrapping to the
// lowest asserted request. The pointer register lives in the parent.
// Ports:
//   req     - request vector
//   pointer - index to start the search from (must be < N)
//   grant   - one-hot grant, all zero when nothing is requested
//   index   - binary index of the granted requester
//   any     - at least one request is asserted
module ff574_bank_ctl_rr_arbiter
  import ff574_bank_ctl_pkg::*;
#(
  parameter int unsigned N  = DefNreq,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;
  logic          hi_any;

  // Scan downwards so the last hit is the lowest index: lo_idx is the lowest
  // request overall, hi_idx the lowest request at or above the pointer.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_idx = IW'(j);
        if (IW'(j) >= pointer) begin
          hi_idx = IW'(j);
          hi_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    any   = |req;
    index = hi_any ? hi_idx : lo_idx;
    grant = any ? (N'(1) << index) : '0;
  end

endmodule

// File: rtl/ff574_bank_ctl.sv
// Sequencer/arbiter sharing a bank of 74x574 registers between requesters.
// Writes produce a single clean rising edge on the addressed reg_clk with
// bus_d set up one cycle before and held one cycle after; reads open a
// two-cycle reg_noe window and sample bus_q at the end of it.
// Ports:
//   clk, nreset      - clock, asynchronous active-low reset
//   req, wr          - per-requester request / direction (1 = write)
//   addr, wdata      - flattened per-requester address and write data
//   ack, err         - one-cycle completion pulse, out-of-range flag
//   rdata            - last successfully read value
//   busy             - sequencer is not idle
//   reg_clk, reg_noe - per-register 574 clock and active-low output enable
//   bus_d, bus_q     - shared data-in bus and shared q bus
// All outputs are registered.
module ff574_bank_ctl
  import ff574_bank_ctl_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned NREG = DefNreg,
  parameter int unsigned AW   = DefAw,
  parameter int unsigned DW   = DefDw
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    wr,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [NREG-1:0]    reg_clk,
  output logic [NREG-1:0]    reg_noe,
  output logic [DW-1:0]      bus_d,
  input  logic [DW-1:0]      bus_q
);

  localparam int unsigned PW = idx_width(NREQ);
  localparam logic [NREG-1:0] RegOne = NREG'(1);

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic [AW-1:0]   addr_q;

  logic [NREQ-1:0] req_v;
  logic [NREQ-1:0] wr_v;
  logic [NREQ-1:0] arb_grant;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;
  logic [PW-1:0]   ptr_next;
  logic [AW-1:0]   sel_addr;
  logic            sel_wr;
  logic [DW-1:0]   sel_data;
  logic            sel_oor;

  // An unknown req/wr bit falls into the else path and reads as 0, so a
  // requester driving X never gets granted.
  always_comb begin
    req_v = '0;
    wr_v  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i]) req_v[i] = 1'b1;
      if (wr[i])  wr_v[i]  = 1'b1;
    end
  end

  ff574_bank_ctl_rr_arbiter #(
    .N  (NREQ),
    .IW (PW)
  ) u_arb (
    .req     (req_v),
    .pointer (ptr_q),
    .grant   (arb_grant),
    .index   (arb_idx),
    .any     (arb_any)
  );

  // One-hot mux of the granted requester's fields.
  always_comb begin
    sel_addr = '0;
    sel_wr   = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr = addr[i*AW +: AW];
        sel_wr   = wr_v[i];
        sel_data = wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    sel_oor  = 32'(sel_addr) >= NREG;
    ptr_next = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
  end

  // Reset drops reg_clk asynchronously; a falling 574 clock never captures,
  // so an aborted write leaves the register either old or fully new.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      ack     <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      reg_clk <= '0;
      reg_noe <= '1;
      bus_d   <= '0;
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      ack     <= '0;
      err     <= 1'b0;
      reg_clk <= '0;
      unique case (state_q)
        StIdle: begin
          if (arb_any) begin
            gnt_q  <= arb_grant;
            addr_q <= sel_addr;
            ptr_q  <= ptr_next;
            busy   <= 1'b1;
            if (sel_oor) begin
              state_q <= StAck;
              ack     <= arb_grant;
              err     <= 1'b1;
            end else if (sel_wr) begin
              state_q <= StSetup;
              bus_d   <= sel_data;
            end else begin
              state_q <= StOe;
              reg_noe <= ~(RegOne << sel_addr);
            end
          end
        end
        StSetup: begin
          state_q <= StStrobe;
          reg_clk <= RegOne << addr_q;
        end
        StStrobe: begin
          state_q <= StHold;
        end
        StHold: begin
          state_q <= StAck;
          ack     <= gnt_q;
        end
        StOe: begin
          state_q <= StSample;
        end
        StSample: begin
          state_q <= StAck;
          reg_noe <= '1;
          rdata   <= bus_q;
          ack     <= gnt_q;
        end
        StAck: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          reg_noe <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff574_bank_ctl.sv
// Self-checking bench for ff574_bank_ctl: a bank of six 574 models on the
// shared buses, a transaction-level reference model (round-robin pick plus
// per-kind latency table) and directed plus randomized requesters.
module tb_ff574_bank_ctl;

  localparam int NREQ = 4;
  localparam int NREG = 6;
  localparam int AW   = 3;
  localparam int DW   = 8;

  logic                clk = 1'b0;
  logic                nreset;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     wr;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ*DW-1:0]  wdata;
  logic [NREQ-1:0]     ack;
  logic                err;
  logic [DW-1:0]       rdata;
  logic                busy;
  logic [NREG-1:0]     reg_clk;
  logic [NREG-1:0]     reg_noe;
  logic [DW-1:0]       bus_d;
  logic [DW-1:0]       bus_q;

  ff574_bank_ctl #(
    .NREQ (NREQ),
    .NREG (NREG),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk     (clk),
    .nreset  (nreset),
    .req     (req),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .ack     (ack),
    .err     (err),
    .rdata   (rdata),
    .busy    (busy),
    .reg_clk (reg_clk),
    .reg_noe (reg_noe),
    .bus_d   (bus_d),
    .bus_q   (bus_q)
  );

  always #5 clk = ~clk;

  // 574 bank: capture bus_d on each rising reg_clk bit; q bus floats to 0.
  logic [DW-1:0]   bank [NREG] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
  logic [NREG-1:0] clk_prev = '0;

  always @(reg_clk) begin
    for (int j = 0; j < NREG; j++) begin
      if (reg_clk[j] && !clk_prev[j]) bank[j] = bus_d;
    end
    clk_prev = reg_clk;
  end

  always_comb begin
    bus_q = '0;
    for (int j = 0; j < NREG; j++) begin
      if (!reg_noe[j]) bus_q = bank[j];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [NREG] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
  int            cyc, t_g, t_req, t_a, t_len, next_free, mp;
  bit            t_valid, t_wr, t_oor;
  logic [DW-1:0] t_d, m_bus_d, m_rdata;

  int            pick, p_a, p_len;
  bit            p_wr, p_oor;
  logic [DW-1:0] p_d;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Candidate transaction if the controller were free at the coming edge.
  always_comb begin
    pick = rr_pick(req, mp);
    p_a  = 0;
    p_wr = 1'b0;
    p_d  = '0;
    if (pick >= 0) begin
      p_a  = int'(addr[pick*AW +: AW]);
      p_wr = wr[pick];
      p_d  = wdata[pick*DW +: DW];
    end
    p_oor = p_a >= NREG;
    p_len = p_oor ? 1 : (p_wr ? 4 : 3);
  end

  // cyc counts edges; a transaction granted at edge t_g is in cycle
  // k = cyc - t_g + 1, acks in cycle t_len, and the next grant may happen
  // at edge t_g + t_len + 1.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cyc       <= 0;
      t_valid   <= 1'b0;
      t_g       <= 0;
      next_free <= 0;
      mp        <= 0;
      m_rdata   <= '0;
      m_bus_d   <= '0;
    end else begin
      cyc <= cyc + 1;
      if (t_valid && t_wr && !t_oor && (cyc + 1 - t_g + 1) == 2) m_mem[t_a] <= t_d;
      if (t_valid && !t_wr && !t_oor && (cyc + 1 - t_g + 1) == t_len) m_rdata <= m_mem[t_a];
      if (cyc + 1 >= next_free && pick >= 0) begin
        t_valid   <= 1'b1;
        t_g       <= cyc + 1;
        t_req     <= pick;
        t_wr      <= p_wr;
        t_a       <= p_a;
        t_d       <= p_d;
        t_oor     <= p_oor;
        t_len     <= p_len;
        next_free <= cyc + 1 + p_len + 1;
        mp        <= (pick + 1) % NREQ;
        if (p_wr && !p_oor) m_bus_d <= p_d;
      end
    end
  end

  int              e_k;
  bit              e_busy, e_err;
  logic [NREQ-1:0] e_ack;
  logic [NREG-1:0] e_clk, e_noe;

  always_comb begin
    e_k    = t_valid ? (cyc - t_g + 1) : 0;
    e_busy = t_valid && e_k >= 1 && e_k <= t_len;
    e_ack  = '0;
    e_err  = 1'b0;
    e_clk  = '0;
    e_noe  = '1;
    if (t_valid && e_k == t_len) begin
      e_ack[t_req] = 1'b1;
      e_err        = t_oor;
    end
    if (t_valid && t_wr && !t_oor && e_k == 2) e_clk[t_a] = 1'b1;
    if (t_valid && !t_wr && !t_oor && (e_k == 1 || e_k == 2)) e_noe[t_a] = 1'b0;
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (!nreset) begin
      check("rst_ack",     32'(ack),     32'(0));
      check("rst_err",     32'(err),     32'(0));
      check("rst_busy",    32'(busy),    32'(0));
      check("rst_reg_clk", 32'(reg_clk), 32'(0));
      check("rst_reg_noe", 32'(reg_noe), 32'(6'h3F));
      check("rst_rdata",   32'(rdata),   32'(0));
      check("rst_bus_d",   32'(bus_d),   32'(0));
    end else begin
      check("ack",     32'(ack),     32'(e_ack));
      check("err",     32'(err),     32'(e_err));
      check("busy",    32'(busy),    32'(e_busy));
      check("reg_clk", 32'(reg_clk), 32'(e_clk));
      check("reg_noe", 32'(reg_noe), 32'(e_noe));
      check("bus_d",   32'(bus_d),   32'(m_bus_d));
      check("rdata",   32'(rdata),   32'(m_rdata));
      if (t_valid && e_k == t_len && t_wr && !t_oor)
        check("bank", 32'(bank[t_a]), 32'(m_mem[t_a]));
    end
  end

  // ---------------- stimulus ----------------
  // Waits for requester i's ack (bounded), dropping req during the ack cycle.
  task automatic wait_ack(input int i, output int clk_cnt, output int noe_cnt,
                          output bit got_err);
    bit done;
    done    = 1'b0;
    clk_cnt = 0;
    noe_cnt = 0;
    got_err = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      #2;
      if (reg_clk != '0) clk_cnt++;
      if (reg_noe != '1) noe_cnt++;
      if (ack[i]) begin
        got_err = err;
        req[i]  = 1'b0;
        done    = 1'b1;
      end
    end
    check("ack_timeout", 32'(done), 32'(1));
  endtask

  task automatic do_txn(input int i, input bit w, input int a, input logic [DW-1:0] d,
                        output int clk_cnt, output int noe_cnt, output bit got_err);
    wr[i]              = w;
    addr[i*AW +: AW]   = AW'(a);
    wdata[i*DW +: DW]  = d;
    req[i]             = 1'b1;
    wait_ack(i, clk_cnt, noe_cnt, got_err);
  endtask

  int cc, nc, n_ack;
  bit ge, seen;
  int order [5];

  initial begin
    nreset = 1'b0;
    req    = 4'b0001;
    wr     = 4'b0001;
    addr   = '0;
    wdata  = '0;
    addr[2:0]  = 3'd3;
    wdata[7:0] = 8'hA5;
    repeat (3) @(negedge clk);
    #2;
    nreset = 1'b1;

    // Requester 0 write A5 to reg 3, pending across reset release.
    wait_ack(0, cc, nc, ge);
    check("wr_a5_strobes", 32'(cc), 32'(1));
    check("wr_a5_bank3",   32'(bank[3]), 32'(8'hA5));

    // Requester 2 reads it back.
    do_txn(2, 1'b0, 3, 8'h00, cc, nc, ge);
    check("rd_noe_cycles", 32'(nc), 32'(2));
    check("rd_strobes",    32'(cc), 32'(0));
    check("rd_rdata",      32'(rdata), 32'(8'hA5));

    // Requester 1 writes out-of-range address 7.
    do_txn(1, 1'b1, 7, 8'h5A, cc, nc, ge);
    check("oor_err",     32'(ge), 32'(1));
    check("oor_strobes", 32'(cc), 32'(0));
    check("oor_noe",     32'(nc), 32'(0));
    check("oor_rdata",   32'(rdata), 32'(8'hA5));

    // Reset in the middle of a write of 3C over 11 in reg 5.
    do_txn(0, 1'b1, 5, 8'h11, cc, nc, ge);
    check("pre_bank5", 32'(bank[5]), 32'(8'h11));
    wr[3]           = 1'b1;
    addr[9 +: AW]   = 3'd5;
    wdata[24 +: DW] = 8'h3C;
    req[3]          = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #2;
      if (reg_clk[5]) seen = 1'b1;
    end
    check("strobe_seen", 32'(seen), 32'(1));
    nreset = 1'b0;
    req    = '0;
    #1;
    check("abort_clk_fall", 32'(reg_clk), 32'(0));
    check("abort_no_ack",   32'(ack), 32'(0));
    check("abort_bank5", 32'((bank[5] == 8'h11) || (bank[5] == 8'h3C)), 32'(1));
    @(negedge clk);
    #2;
    nreset = 1'b1;

    // All four requesters hold writes continuously: 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW]  = AW'(i);
      wdata[i*DW +: DW] = DW'($urandom);
    end
    wr    = 4'b1111;
    req   = 4'b1111;
    n_ack = 0;
    for (int c = 0; c < 40 && n_ack < 5; c++) begin
      @(negedge clk);
      #2;
      if (ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (ack[i]) order[n_ack] = i;
        n_ack++;
        if (n_ack == 5) req = '0;
      end
    end
    check("rr_ack_count", 32'(n_ack), 32'(5));
    for (int j = 0; j < 5; j++) check("rr_order", 32'(order[j]), 32'(j % NREQ));

    // Reg 5 after the aborted write still reads a legal value.
    do_txn(1, 1'b0, 5, 8'h00, cc, nc, ge);
    check("post_abort_rd", 32'(rdata), 32'(bank[5]));

    // Randomized contention; requesters drop req on ack, last cycles drain.
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (ack[i]) req[i] = 1'b0;
        end else if (c < 840 && $urandom_range(3) == 0) begin
          wr[i]             = 1'($urandom_range(1));
          addr[i*AW +: AW]  = AW'($urandom_range(7));
          wdata[i*DW +: DW] = DW'($urandom);
          req[i]            = 1'b1;
        end
      end
    end
    check("drained", 32'(req), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
